// File: rtl/freq_bcd_normalizer_if.sv
// Handshake and display bus between the frequency counter stage and the BCD normalizer.
// The master side requests a conversion; the slave side returns four digits plus a scale exponent.
interface freq_bcd_normalizer_if #(
    parameter int BIN_W = 20
) ();
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             ready;
    logic             done_tick;
    logic [3:0]       dig3;
    logic [3:0]       dig2;
    logic [3:0]       dig1;
    logic [3:0]       dig0;
    logic [1:0]       exp;

    modport master (
        output start,
        output bin,
        input  ready,
        input  done_tick,
        input  dig3,
        input  dig2,
        input  dig1,
        input  dig0,
        input  exp
    );

    modport slave (
        input  start,
        input  bin,
        output ready,
        output done_tick,
        output dig3,
        output dig2,
        output dig1,
        output dig0,
        output exp
    );
endinterface

// File: rtl/freq_bcd_normalizer.sv
// Converts a binary frequency count to 7 BCD digits (double dabble), then left-justifies
// the result into four displayed digits plus a decimal exponent, truncating the rest.
module freq_bcd_normalizer #(
    parameter int BIN_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    freq_bcd_normalizer_if.slave  bus
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_r;
    logic [BIN_W-1:0]       bin_r;
    logic [BCD_W-1:0]       bcd_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [1:0]             shcnt_r;
    logic [BCD_W-1:0]       bcd_adj_s;
    logic [BCD_W+BIN_W-1:0] shift_s;

    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Double-dabble step: correct every digit, then shift the whole BCD:binary word left
    always_comb begin
        bcd_adj_s = {BCD_W{1'b0}};
        for (int i = 0; i < 7; i++) begin
            bcd_adj_s[4*i +: 4] = add3(bcd_r[4*i +: 4]);
        end
        shift_s = {bcd_adj_s, bin_r} << 1;
    end

    // Control FSM with all datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            bin_r         <= {BIN_W{1'b0}};
            bcd_r         <= {BCD_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            shcnt_r       <= 2'd0;
            bus.ready     <= 1'b1;
            bus.done_tick <= 1'b0;
            bus.dig3      <= 4'd0;
            bus.dig2      <= 4'd0;
            bus.dig1      <= 4'd0;
            bus.dig0      <= 4'd0;
            bus.exp       <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.done_tick <= 1'b0;
                    if (bus.start) begin
                        bin_r     <= bus.bin;
                        bcd_r     <= {BCD_W{1'b0}};
                        cnt_r     <= CNT_W'(BIN_W);
                        shcnt_r   <= 2'd0;
                        bus.ready <= 1'b0;
                        state_r   <= CONV;
                    end else begin
                        bus.ready <= 1'b1;
                    end
                end
                CONV: begin
                    {bcd_r, bin_r} <= shift_s;
                    cnt_r          <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= NORM;
                    end else begin
                        state_r <= CONV;
                    end
                end
                NORM: begin
                    // Stop once the leading digit is significant or three digits have been dropped
                    if ((bcd_r[27:24] != 4'd0) || (shcnt_r == 2'd3)) begin
                        state_r <= DONE;
                    end else begin
                        bcd_r   <= {bcd_r[23:0], 4'd0};
                        shcnt_r <= shcnt_r + 2'd1;
                    end
                end
                DONE: begin
                    // Outputs change together with done_tick so they stay stable between pulses
                    bus.dig3      <= bcd_r[27:24];
                    bus.dig2      <= bcd_r[23:20];
                    bus.dig1      <= bcd_r[19:16];
                    bus.dig0      <= bcd_r[15:12];
                    bus.exp       <= 2'd3 - shcnt_r;
                    bus.done_tick <= 1'b1;
                    bus.ready     <= 1'b1;
                    state_r       <= IDLE;
                end
                default: begin
                    state_r       <= IDLE;
                    bus.ready     <= 1'b1;
                    bus.done_tick <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_bcd_normalizer.sv
// Self-checking bench for freq_bcd_normalizer: directed table, handshake corner cases,
// and random counts compared against a decimal-arithmetic reference model.
module tb_freq_bcd_normalizer;

    localparam int BIN_W = 20;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    freq_bcd_normalizer_if #(.BIN_W(BIN_W)) bus ();

    freq_bcd_normalizer #(.BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic [15:0]      digs;
        logic [1:0]       e;
        int               lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] cur_digs();
        return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
    endfunction

    // Reference: choose the fewest left shifts (max 3) that make the 7-digit value reach 10^6
    task automatic model(input int unsigned v, output logic [15:0] digs,
                         output logic [1:0] e, output int lat);
        longint unsigned scaled;
        longint unsigned top;
        int s;
        bit found;
        s = 3;
        found = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            scaled = longint'(v) * (10 ** k);
            if (!found && scaled >= 64'd1000000) begin
                s = k;
                found = 1'b1;
            end
        end
        top  = (longint'(v) * (10 ** s)) / 1000;
        digs = {4'(top / 1000 % 10), 4'(top / 100 % 10), 4'(top / 10 % 10), 4'(top % 10)};
        e    = 2'(3 - s);
        lat  = 22 + s;
    endtask

    task automatic convert(input logic [BIN_W-1:0] v, output int lat,
                           output logic [15:0] digs, output logic [1:0] e);
        @(negedge clk);
        bus.bin   = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        digs = 16'h0000;
        e    = 2'd0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_tick) begin
                lat  = i;
                digs = cur_digs();
                e    = bus.exp;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("done_pulse_width", longint'(bus.done_tick), 64'd0);
    endtask

    int               lat;
    logic [15:0]      digs;
    logic [1:0]       e;
    int               m_lat;
    logic [15:0]      m_digs;
    logic [1:0]       m_e;
    int               n_done;
    int               first;
    int               rdy_bad;
    logic [BIN_W-1:0] v;

    initial begin
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.bin   = '0;
        rst       = 1'b1;

        vecs[0] = '{20'd9999,    16'h9999, 2'd0, 25};
        vecs[1] = '{20'd10000,   16'h1000, 2'd1, 24};
        vecs[2] = '{20'd123456,  16'h1234, 2'd2, 23};
        vecs[3] = '{20'd1048575, 16'h1048, 2'd3, 22};
        vecs[4] = '{20'd0,       16'h0000, 2'd0, 25};
        vecs[5] = '{20'd500,     16'h0500, 2'd0, 25};
        vecs[6] = '{20'd999999,  16'h9999, 2'd2, 23};
        vecs[7] = '{20'd1000000, 16'h1000, 2'd3, 22};
        vecs[8] = '{20'd1000,    16'h1000, 2'd0, 25};
        vecs[9] = '{20'd99999,   16'h9999, 2'd1, 24};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", longint'(bus.ready), 64'd1);
        chk("reset_done", longint'(bus.done_tick), 64'd0);
        chk("reset_digs", longint'(cur_digs()), 64'd0);
        chk("reset_exp", longint'(bus.exp), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, lat, digs, e);
            chk($sformatf("vec%0d_latency", i), longint'(lat), longint'(vecs[i].lat));
            chk($sformatf("vec%0d_digs", i), longint'(digs), longint'(vecs[i].digs));
            chk($sformatf("vec%0d_exp", i), longint'(e), longint'(vecs[i].e));
        end

        // start re-asserted with another value during CONV must be ignored
        @(negedge clk);
        bus.bin   = 20'd9999;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_done  = 0;
        first   = 0;
        rdy_bad = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) begin
                bus.start = 1'b1;
                bus.bin   = 20'd1048575;
            end
            if (i == 12) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done_tick) begin
                n_done++;
                if (first == 0) begin
                    first = i;
                    digs  = cur_digs();
                    e     = bus.exp;
                    chk("ignore_ready_at_done", longint'(bus.ready), 64'd1);
                end
            end
            if (first == 0 && bus.ready) begin
                rdy_bad++;
            end
        end
        chk("ignore_done_count", longint'(n_done), 64'd1);
        chk("ignore_latency", longint'(first), 64'd25);
        chk("ignore_digs", longint'(digs), 64'h9999);
        chk("ignore_exp", longint'(e), 64'd0);
        chk("ignore_ready_low", longint'(rdy_bad), 64'd0);

        // reset mid-conversion aborts it
        @(negedge clk);
        bus.bin   = 20'd123456;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", longint'(bus.ready), 64'd1);
        chk("abort_done", longint'(bus.done_tick), 64'd0);
        chk("abort_digs", longint'(cur_digs()), 64'd0);
        chk("abort_exp", longint'(bus.exp), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_tick) begin
                n_done++;
            end
        end
        chk("abort_no_done", longint'(n_done), 64'd0);
        convert(20'd500, lat, digs, e);
        chk("after_abort_latency", longint'(lat), 64'd25);
        chk("after_abort_digs", longint'(digs), 64'h0500);
        chk("after_abort_exp", longint'(e), 64'd0);

        // random counts across all magnitudes against the reference model
        for (int i = 0; i < 40; i++) begin
            v = BIN_W'($urandom_range(0, 1048575) >> $urandom_range(0, 19));
            model(int'(v), m_digs, m_e, m_lat);
            convert(v, lat, digs, e);
            chk($sformatf("rand%0d_latency(bin=%0d)", i, v), longint'(lat), longint'(m_lat));
            chk($sformatf("rand%0d_digs(bin=%0d)", i, v), longint'(digs), longint'(m_digs));
            chk($sformatf("rand%0d_exp(bin=%0d)", i, v), longint'(e), longint'(m_e));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bus.bin = BIN_W'($urandom_range(0, 1048575));
            end
            @(posedge clk);
            #1;
            chk($sformatf("rand%0d_hold_digs", i), longint'(cur_digs()), longint'(m_digs));
            chk($sformatf("rand%0d_hold_exp", i), longint'(bus.exp), longint'(m_e));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
